// File: rtl/window_3x3_gen.sv
// 3x3 neighbourhood generator: two line buffers plus a 3x3 register window
// fed from a raster-order pixel stream, strobing each full interior window.
module window_3x3_gen #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_valid,
  input  logic                  sof,
  output logic [DATA_WIDTH-1:0] a0,
  output logic [DATA_WIDTH-1:0] b0,
  output logic [DATA_WIDTH-1:0] c0,
  output logic [DATA_WIDTH-1:0] a1,
  output logic [DATA_WIDTH-1:0] b1,
  output logic [DATA_WIDTH-1:0] c1,
  output logic [DATA_WIDTH-1:0] a2,
  output logic [DATA_WIDTH-1:0] b2,
  output logic [DATA_WIDTH-1:0] c2,
  output logic                  win_valid,
  output logic                  frame_done
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;

  logic [COL_W-1:0] eff_col_c;
  logic [ROW_W-1:0] eff_row_c;
  logic [COL_W-1:0] next_col_c;
  logic [ROW_W-1:0] next_row_c;
  logic             last_col_c;
  logic             last_row_c;
  logic             interior_c;

  logic [DATA_WIDTH-1:0] t0_c;
  logic [DATA_WIDTH-1:0] t1_c;

  // lb0 holds line row-2, lb1 holds line row-1; contents are never reset
  logic [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];

  // Position of the incoming pixel (sof forces (0,0)) and the following position
  always_comb begin
    eff_col_c  = col_cnt;
    eff_row_c  = row_cnt;
    if (sof) begin
      eff_col_c = '0;
      eff_row_c = '0;
    end
    last_col_c = (eff_col_c == COL_W'(IMG_WIDTH - 1));
    last_row_c = (eff_row_c == ROW_W'(IMG_HEIGHT - 1));
    interior_c = (eff_row_c >= ROW_W'(2)) && (eff_col_c >= COL_W'(2));
    next_col_c = eff_col_c + COL_W'(1);
    next_row_c = eff_row_c;
    if (last_col_c) begin
      next_col_c = '0;
      next_row_c = last_row_c ? '0 : (eff_row_c + ROW_W'(1));
    end
    t0_c = lb0[eff_col_c];
    t1_c = lb1[eff_col_c];
  end

  // Line buffer update: read-before-write at the same column
  always_ff @(posedge clk) begin
    if (pix_valid && !rst) begin
      lb0[eff_col_c] <= t1_c;
      lb1[eff_col_c] <= pix_in;
    end
  end

  // Counters, window shift and strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt    <= '0;
      row_cnt    <= '0;
      a0         <= '0;
      b0         <= '0;
      c0         <= '0;
      a1         <= '0;
      b1         <= '0;
      c1         <= '0;
      a2         <= '0;
      b2         <= '0;
      c2         <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (pix_valid) begin
      col_cnt    <= next_col_c;
      row_cnt    <= next_row_c;
      a0         <= b0;
      b0         <= c0;
      c0         <= t0_c;
      a1         <= b1;
      b1         <= c1;
      c1         <= t1_c;
      a2         <= b2;
      b2         <= c2;
      c2         <= pix_in;
      win_valid  <= interior_c;
      frame_done <= interior_c && last_row_c && last_col_c;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule
